// File: rtl/video_axis_pkg.sv
// Shared types and constants for the parallel-video to AXI4-Stream bridge.
package video_axis_pkg;

    localparam int PIX_W = 24;
    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        WAIT_SOF,
        ACTIVE,
        DROP
    } state_t;

    // FIFO word: sideband flags ride above the pixel so one array holds everything
    typedef struct packed {
        logic             user;
        logic             last;
        logic [PIX_W-1:0] data;
    } axis_word_t;

    localparam int WORD_W = $bits(axis_word_t);

    function automatic logic [PIX_W-1:0] pack_pixel(input logic [7:0] r,
                                                    input logic [7:0] g,
                                                    input logic [7:0] b);
        logic [PIX_W-1:0] p;
        p = '0;
        p[R_LSB +: 8] = r;
        p[G_LSB +: 8] = g;
        p[B_LSB +: 8] = b;
        return p;
    endfunction

endpackage

// File: rtl/video_to_axis_if.sv
// AXI4-Stream video bus carrying 24-bit RGB with start-of-frame and end-of-line flags.
interface video_to_axis_if;
    import video_axis_pkg::*;

    logic [PIX_W-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tuser;
    logic             tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO: block-RAM array with registered read feeding a first-word fall-through output register.
module sync_fifo #(
    parameter int  DEPTH = 2048,
    parameter int  WIDTH = 26,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    mem_cnt_reg;
    logic [LW-1:0]    level_reg;
    logic [WIDTH-1:0] dout_reg;
    logic             dout_valid_reg;
    logic             pop_ok;
    logic             load;

    // Level includes the output register, so capacity is DEPTH words in total
    // and the array itself can never be written while it is completely full.
    assign pop_ok = pop & dout_valid_reg;
    assign load   = (mem_cnt_reg != '0) & (~dout_valid_reg | pop_ok);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            mem_cnt_reg    <= '0;
            level_reg      <= '0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (load) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
                dout_reg   <= mem[rd_ptr_reg];
            end
            mem_cnt_reg <= mem_cnt_reg + LW'(push) - LW'(load);
            level_reg   <= level_reg + LW'(push) - LW'(pop_ok);
            if (load) begin
                dout_valid_reg <= 1'b1;
            end else if (pop_ok) begin
                dout_valid_reg <= 1'b0;
            end
        end
    end

    assign dout  = dout_reg;
    assign empty = ~dout_valid_reg;
    assign full  = (level_reg == LW'(DEPTH));
    assign level = level_reg;

endmodule

// File: rtl/video_to_axis.sv
// Captures vs/de/RGB video, tags start-of-frame and end-of-line, and queues it onto AXI4-Stream.
module video_to_axis
    import video_axis_pkg::*;
#(
    parameter int  FIFO_DEPTH = 2048,
    parameter bit  VS_POL     = 1'b1,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vid_vs,
    input  logic                    vid_de,
    input  logic [7:0]              vid_r,
    input  logic [7:0]              vid_g,
    input  logic [7:0]              vid_b,
    video_to_axis_if.master         m_axis,
    output logic                    overflow,
    input  logic                    ovf_clr,
    output logic [15:0]             frame_cnt,
    output logic [LW-1:0]           fifo_level
);

    state_t           state_reg, state_next;
    logic             vs_act_reg;
    logic             vs_edge;
    logic             sof_armed_reg, sof_armed_next;
    logic             hold_valid_reg, hold_valid_next;
    logic             hold_sof_reg, hold_sof_next;
    logic [PIX_W-1:0] hold_data_reg, hold_data_next;
    logic             pushed_any_reg, pushed_any_next;
    logic             overflow_reg, overflow_next;
    logic [15:0]      frame_cnt_reg, frame_cnt_next;
    logic             push_ok;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [PIX_W-1:0] pixel;
    axis_word_t       push_word;
    axis_word_t       fifo_word;

    assign pixel    = pack_pixel(vid_r, vid_g, vid_b);
    assign vs_edge  = (vid_vs == VS_POL) && !vs_act_reg;
    assign fifo_pop = ~fifo_empty & m_axis.tready;

    always_comb begin
        state_next      = state_reg;
        sof_armed_next  = sof_armed_reg;
        hold_valid_next = hold_valid_reg;
        hold_sof_next   = hold_sof_reg;
        hold_data_next  = hold_data_reg;
        pushed_any_next = pushed_any_reg;
        overflow_next   = overflow_reg;
        frame_cnt_next  = frame_cnt_reg;
        push_ok         = 1'b0;
        // The held pixel closes its line when no pixel follows it this cycle
        push_word       = '{user: hold_sof_reg, last: ~vid_de, data: hold_data_reg};

        if (ovf_clr) begin
            overflow_next = 1'b0;
        end

        unique case (state_reg)
            WAIT_SOF: begin
                if (sof_armed_reg && vid_de) begin
                    hold_valid_next = 1'b1;
                    hold_sof_next   = 1'b1;
                    hold_data_next  = pixel;
                    sof_armed_next  = 1'b0;
                    state_next      = ACTIVE;
                end
            end
            ACTIVE: begin
                push_ok = hold_valid_reg && (!fifo_full || fifo_pop);
                if (hold_valid_reg && !push_ok) begin
                    overflow_next   = 1'b1;
                    hold_valid_next = 1'b0;
                    pushed_any_next = 1'b0;
                    state_next      = vs_edge ? WAIT_SOF : DROP;
                end else begin
                    if (push_ok) begin
                        pushed_any_next = 1'b1;
                    end
                    hold_valid_next = vid_de;
                    if (vid_de) begin
                        hold_sof_next  = sof_armed_reg;
                        hold_data_next = pixel;
                        sof_armed_next = 1'b0;
                    end
                    if (vs_edge) begin
                        if (pushed_any_next) begin
                            frame_cnt_next = frame_cnt_reg + 16'd1;
                        end
                        pushed_any_next = 1'b0;
                    end
                end
            end
            DROP: begin
                if (vs_edge) begin
                    state_next = WAIT_SOF;
                end
            end
            default: state_next = WAIT_SOF;
        endcase

        if (vs_edge) begin
            sof_armed_next = 1'b1;
        end
    end

    // vs_act_reg comes out of reset high so an already-active vsync is not mistaken for an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= WAIT_SOF;
            vs_act_reg     <= 1'b1;
            sof_armed_reg  <= 1'b0;
            hold_valid_reg <= 1'b0;
            hold_sof_reg   <= 1'b0;
            hold_data_reg  <= '0;
            pushed_any_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            frame_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            vs_act_reg     <= (vid_vs == VS_POL);
            sof_armed_reg  <= sof_armed_next;
            hold_valid_reg <= hold_valid_next;
            hold_sof_reg   <= hold_sof_next;
            hold_data_reg  <= hold_data_next;
            pushed_any_reg <= pushed_any_next;
            overflow_reg   <= overflow_next;
            frame_cnt_reg  <= frame_cnt_next;
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .din   (push_word),
        .pop   (fifo_pop),
        .dout  (fifo_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign m_axis.tdata  = fifo_word.data;
    assign m_axis.tuser  = fifo_word.user;
    assign m_axis.tlast  = fifo_word.last;
    assign m_axis.tvalid = ~fifo_empty;
    assign overflow      = overflow_reg;
    assign frame_cnt     = frame_cnt_reg;

endmodule

// File: tb/tb_video_to_axis.sv
// Directed bench: two bridges (depth 16 / positive vsync, depth 4 / negative vsync) share one video source.
`timescale 1ns/1ps
module tb_video_to_axis;

    localparam int LW_A = $clog2(16) + 1;
    localparam int LW_B = $clog2(4) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vs = 1'b0;
    logic de = 1'b0;
    logic ovf_clr = 1'b0;
    logic [7:0] pr = 8'd0;
    logic [7:0] pg = 8'd0;
    logic [7:0] pb = 8'd0;
    logic vs_n;
    logic overflow_a, overflow_b;
    logic [15:0] fc_a, fc_b;
    logic [LW_A-1:0] lvl_a;
    logic [LW_B-1:0] lvl_b;

    assign vs_n = ~vs;

    video_to_axis_if axis_a();
    video_to_axis_if axis_b();

    video_to_axis #(.FIFO_DEPTH(16), .VS_POL(1'b1)) dut_a (
        .clk(clk), .rst(rst), .vid_vs(vs), .vid_de(de),
        .vid_r(pr), .vid_g(pg), .vid_b(pb), .m_axis(axis_a),
        .overflow(overflow_a), .ovf_clr(ovf_clr), .frame_cnt(fc_a), .fifo_level(lvl_a)
    );

    video_to_axis #(.FIFO_DEPTH(4), .VS_POL(1'b0)) dut_b (
        .clk(clk), .rst(rst), .vid_vs(vs_n), .vid_de(de),
        .vid_r(pr), .vid_g(pg), .vid_b(pb), .m_axis(axis_b),
        .overflow(overflow_b), .ovf_clr(ovf_clr), .frame_cnt(fc_b), .fifo_level(lvl_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    bit tr_toggle_a = 1'b0;
    bit tr_b = 1'b1;

    logic [25:0] beats_a [0:511];
    logic [25:0] beats_b [0:511];
    int cnt_a = 0;
    int cnt_b = 0;
    logic [25:0] word_a, word_b;
    logic stalled_a = 1'b0, stalled_b = 1'b0;
    logic [25:0] stall_word_a = '0, stall_word_b = '0;
    int stall_err_a = 0, stall_err_b = 0, stall_seen_a = 0;

    assign word_a = {axis_a.tuser, axis_a.tlast, axis_a.tdata};
    assign word_b = {axis_b.tuser, axis_b.tlast, axis_b.tdata};

    // Handshakes complete at the next rising edge; sample on the falling edge.
    always @(negedge clk) begin
        if (axis_a.tvalid === 1'b1 && axis_a.tready === 1'b1 && cnt_a < 512) begin
            beats_a[cnt_a] <= word_a;
            cnt_a <= cnt_a + 1;
        end
        if (stalled_a) begin
            stall_seen_a <= stall_seen_a + 1;
            if (!(axis_a.tvalid === 1'b1 && word_a === stall_word_a))
                stall_err_a <= stall_err_a + 1;
        end
        stalled_a    <= (axis_a.tvalid === 1'b1) && (axis_a.tready !== 1'b1) && (rst !== 1'b1);
        stall_word_a <= word_a;
    end

    always @(negedge clk) begin
        if (axis_b.tvalid === 1'b1 && axis_b.tready === 1'b1 && cnt_b < 512) begin
            beats_b[cnt_b] <= word_b;
            cnt_b <= cnt_b + 1;
        end
        if (stalled_b && !(axis_b.tvalid === 1'b1 && word_b === stall_word_b))
            stall_err_b <= stall_err_b + 1;
        stalled_b    <= (axis_b.tvalid === 1'b1) && (axis_b.tready !== 1'b1) && (rst !== 1'b1);
        stall_word_b <= word_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int f, input int y, input int x);
        logic [7:0] k;
        k = 8'(y * 8 + x);
        return {8'hFF - k, k, 8'(f)};
    endfunction

    function automatic logic [25:0] exp_word(input int f, input int y, input int x);
        logic u, l;
        u = (y == 0 && x == 0);
        l = (x == 7);
        return {u, l, pix(f, y, x)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        axis_a.tready = tr_toggle_a ? (cyc % 3 == 0) : 1'b1;
        axis_b.tready = tr_b;
    endtask

    task automatic drive(input logic vs_v, input logic de_v, input logic [23:0] p);
        vs = vs_v;
        de = de_v;
        pr = p[23:16];
        pg = p[15:8];
        pb = p[7:0];
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 24'd0);
    endtask

    task automatic vsync();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 24'd0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 24'd0);
    endtask

    task automatic send_line(input int f, input int y, input int gap);
        for (int x = 0; x < 8; x++) drive(1'b0, 1'b1, pix(f, y, x));
        idle(gap);
    endtask

    task automatic frame_body(input int f, input int first_line, input int gap);
        for (int y = first_line; y < 4; y++) send_line(f, y, gap);
    endtask

    task automatic check_frame(input bit use_b, input int base, input int f, input string tag);
        int nlast;
        logic [25:0] got;
        nlast = 0;
        for (int i = 0; i < 32; i++) begin
            got = use_b ? beats_b[base + i] : beats_a[base + i];
            if (got[24] === 1'b1) nlast++;
            check($sformatf("%s_beat%0d", tag, i), 32'(got), 32'(exp_word(f, i / 8, i % 8)));
        end
        check({tag, "_tlast_count"}, nlast, 4);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_a, base_b;
        axis_a.tready = 1'b1;
        axis_b.tready = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        check("rst_tvalid_a", 32'(axis_a.tvalid), 0);
        check("rst_tvalid_b", 32'(axis_b.tvalid), 0);
        check("rst_tdata_a", 32'(axis_a.tdata), 0);
        check("rst_ovf_a", 32'(overflow_a), 0);
        check("rst_fc_a", 32'(fc_a), 0);
        check("rst_lvl_a", 32'(lvl_a), 0);
        check("rst_lvl_b", 32'(lvl_b), 0);
        rst = 1'b0;

        // Video already running with no vsync seen yet
        send_line(99, 2, 4);
        send_line(99, 3, 4);
        idle(10);
        check("midframe_beats_a", cnt_a, 0);
        check("midframe_beats_b", cnt_b, 0);
        check("midframe_lvl_a", 32'(lvl_a), 0);

        // Frame 0, both sinks always ready
        vsync();
        base_a = cnt_a;
        base_b = cnt_b;
        frame_body(0, 0, 4);
        idle(20);
        check("f0_cnt_a", cnt_a - base_a, 32);
        check("f0_cnt_b", cnt_b - base_b, 32);
        check("f0_first_a", 32'(beats_a[base_a]), 32'h2FF0000);
        check_frame(1'b0, base_a, 0, "f0_a");
        check_frame(1'b1, base_b, 0, "f0_b");
        check("f0_fc_before_a", 32'(fc_a), 0);
        check("f0_fc_before_b", 32'(fc_b), 0);
        vsync();
        check("f0_fc_after_a", 32'(fc_a), 1);
        check("f0_fc_after_b", 32'(fc_b), 1);

        // Frame 1, sink A ready one cycle in three
        tr_toggle_a = 1'b1;
        base_a = cnt_a;
        base_b = cnt_b;
        frame_body(1, 0, 16);
        idle(40);
        tr_toggle_a = 1'b0;
        check("f1_cnt_a", cnt_a - base_a, 32);
        check("f1_cnt_b", cnt_b - base_b, 32);
        check_frame(1'b0, base_a, 1, "f1_a");
        check_frame(1'b1, base_b, 1, "f1_b");
        check("f1_ovf_a", 32'(overflow_a), 0);
        check("f1_stall_err_a", stall_err_a, 0);
        check("f1_stalls_seen_a", 32'(stall_seen_a > 0), 1);
        vsync();
        check("f1_fc_a", 32'(fc_a), 2);
        check("f1_fc_b", 32'(fc_b), 2);

        // Frame 2, sink B stalled: its 4-deep FIFO overflows on the 5th push
        tr_b = 1'b0;
        base_a = cnt_a;
        base_b = cnt_b;
        for (int x = 0; x < 8; x++) begin
            drive(1'b0, 1'b1, pix(2, 0, x));
            if (x == 4) check("f2_ovf_after4_b", 32'(overflow_b), 0);
            if (x == 5) check("f2_ovf_after5_b", 32'(overflow_b), 1);
        end
        idle(4);
        frame_body(2, 1, 4);
        idle(10);
        check("f2_ovf_b", 32'(overflow_b), 1);
        check("f2_lvl_b", 32'(lvl_b), 4);
        check("f2_ovf_a", 32'(overflow_a), 0);
        check("f2_cnt_b", cnt_b - base_b, 0);
        check("f2_cnt_a", cnt_a - base_a, 32);
        check_frame(1'b0, base_a, 2, "f2_a");
        tr_b = 1'b1;
        idle(10);
        check("f2_drain_cnt_b", cnt_b - base_b, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("f2_drain_b%0d", i), 32'(beats_b[base_b + i]), 32'(exp_word(2, 0, i)));
        check("f2_ovf_sticky_b", 32'(overflow_b), 1);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        check("f2_ovf_clr_b", 32'(overflow_b), 0);
        vsync();
        check("f2_fc_a", 32'(fc_a), 3);
        check("f2_fc_b", 32'(fc_b), 2);

        // Frame 3, B resynchronised
        base_a = cnt_a;
        base_b = cnt_b;
        frame_body(3, 0, 4);
        idle(20);
        check("f3_cnt_b", cnt_b - base_b, 32);
        check_frame(1'b1, base_b, 3, "f3_b");
        check_frame(1'b0, base_a, 3, "f3_a");
        vsync();
        check("f3_fc_a", 32'(fc_a), 4);
        check("f3_fc_b", 32'(fc_b), 3);

        // Frame 4, one-cycle reset in the middle of line 0
        for (int x = 0; x < 4; x++) drive(1'b0, 1'b1, pix(4, 0, x));
        rst = 1'b1;
        drive(1'b0, 1'b1, pix(4, 0, 4));
        rst = 1'b0;
        check("f4_rst_tvalid_a", 32'(axis_a.tvalid), 0);
        check("f4_rst_tvalid_b", 32'(axis_b.tvalid), 0);
        check("f4_rst_lvl_a", 32'(lvl_a), 0);
        check("f4_rst_lvl_b", 32'(lvl_b), 0);
        check("f4_rst_fc_a", 32'(fc_a), 0);
        base_a = cnt_a;
        base_b = cnt_b;
        for (int x = 5; x < 8; x++) drive(1'b0, 1'b1, pix(4, 0, x));
        idle(4);
        frame_body(4, 1, 4);
        idle(10);
        check("f4_cnt_a", cnt_a - base_a, 0);
        check("f4_cnt_b", cnt_b - base_b, 0);
        vsync();
        check("f4_fc_a", 32'(fc_a), 0);
        check("f4_fc_b", 32'(fc_b), 0);

        // Frame 5, output resumes with start-of-frame
        base_a = cnt_a;
        base_b = cnt_b;
        frame_body(5, 0, 4);
        idle(20);
        check("f5_cnt_a", cnt_a - base_a, 32);
        check_frame(1'b0, base_a, 5, "f5_a");
        check_frame(1'b1, base_b, 5, "f5_b");
        vsync();
        check("f5_fc_a", 32'(fc_a), 1);
        check("f5_fc_b", 32'(fc_b), 1);
        check("stall_err_b", stall_err_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
